normalizer: RTL and testbench
=============================

NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have port iClk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port iRst, input, 1, synchronous active-high reset, sampled on the rising edge of iClk.
REQ-003 SHALL have port iStart, input, 1, request to normalize iD; sampled only when the block is idle or done.
REQ-004 SHALL have port iD, input, 32, operand captured on start acceptance.
REQ-005 SHALL have port iSigned, input, 1, mode captured on start acceptance: 0 = unsigned (strip leading zeros), 1 = signed (strip redundant sign bits).
REQ-006 SHALL have port oD, output, 32, the normalized result.
REQ-007 SHALL have port oShamt, output, 5, the left-shift amount applied, so that the operand shifted left by oShamt equals oD.
REQ-008 SHALL have port oZero, output, 1, operand had no normalizing bit (unsigned 0; signed 0x00000000 or 0xFFFFFFFF).
REQ-009 SHALL have port oBusy, output, 1, high while a normalization is in progress.
REQ-010 SHALL have port oDone, output, 1, single-cycle pulse marking oD/oShamt/oZero valid.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, and DONE, plus a 3-bit step counter.
REQ-012 SHALL, in IDLE or DONE with iStart=1, capture iD, iSigned, and the zero condition, set step=4, and enter RUN; oShamt is cleared to 0.
REQ-013 SHALL, in RUN, at each step k (4,3,2,1,0, in that order) with n=2^k, test the working value as follows: unsigned, the top n bits are all 0; signed, the top n+1 bits all equal bit 31.
REQ-014 SHALL, when the REQ-013 test passes, shift the working value left by n with zero fill and set oShamt bit k; otherwise the value and oShamt are unchanged.
REQ-015 SHALL, after step 0, enter DONE; DONE lasts one cycle and then returns to IDLE unless a new start is accepted (REQ-012).
REQ-016 SHALL have a fixed latency: if iStart is sampled in cycle 0, RUN occupies cycles 1-5 and oDone=1 in cycle 6 only.
REQ-017 SHALL drive oBusy=1 exactly in RUN cycles, and oDone=1 exactly in the DONE cycle.
REQ-018 SHALL, for a zero-condition operand, produce oZero=1, oShamt=0, and oD equal to the captured operand, with timing unchanged.
REQ-019 SHALL, for all other operands, produce oZero=0; in unsigned mode oD[31]=1, and in signed mode oD[31]!=oD[30].
REQ-020 SHALL hold oD, oShamt, and oZero stable from DONE until the next accepted start; their values during RUN are unspecified.
REQ-021 SHALL ignore iStart, iD, and iSigned while in RUN, with no queuing.
REQ-022 SHALL accept iStart=1 in the DONE cycle as a back-to-back start, with the same 6-cycle latency.
REQ-023 SHALL produce no combinational path from any input to any output.

Reset
REQ-024 SHALL, when iRst=1 at a clock edge, force IDLE, step=0, oD=0, oShamt=0, oZero=0, oBusy=0, oDone=0.
REQ-025 SHALL give iRst priority over iStart and abort any RUN or DONE in progress with no oDone pulse.
REQ-026 SHALL accept iStart in the first cycle after iRst deasserts.

Verification
REQ-027 SHALL cover: unsigned iD=0x00000001 -> cycle 6 oDone=1, oD=0x80000000, oShamt=31, oZero=0; oBusy=1 in cycles 1-5.
REQ-028 SHALL cover: unsigned iD=0x00012345 -> oD=0x91A28000, oShamt=15; unsigned iD=0x80000000 -> oD=0x80000000, oShamt=0.
REQ-029 SHALL cover: signed iD=0xFFFFFF80 -> oD=0x80000000, oShamt=24; signed iD=0x00000001 -> oD=0x40000000, oShamt=30.
REQ-030 SHALL cover: unsigned iD=0 -> oZero=1, oShamt=0, oD=0; signed iD=0xFFFFFFFF -> oZero=1, oShamt=0, oD=0xFFFFFFFF.
REQ-031 SHALL cover: iStart pulsed in cycle 2 of a run with a different iD -> ignored, first result unchanged; iStart held high in DONE with a new iD -> second oDone exactly 6 cycles later with the correct result.
REQ-032 SHALL cover: iRst asserted in cycle 3 of a run -> next cycle all outputs 0 and no oDone; a new start in the following cycle completes normally.

Source files
------------

// File: rtl/normalizer_if.sv
// Request/result bundle for the normalizer: operand and mode in, normalized
// result, shift amount and status out.
interface normalizer_if;
   logic        iStart;
   logic [31:0] iD;
   logic        iSigned;
   logic [31:0] oD;
   logic [4:0]  oShamt;
   logic        oZero;
   logic        oBusy;
   logic        oDone;

   // Requester side: drives the operand, observes the result.
   modport master (
      output iStart, iD, iSigned,
      input  oD, oShamt, oZero, oBusy, oDone
   );

   // Normalizer side.
   modport slave (
      input  iStart, iD, iSigned,
      output oD, oShamt, oZero, oBusy, oDone
   );
endinterface

// File: rtl/normalizer.sv
// Iterative 32-bit normalizer. Strips leading zeros (unsigned) or redundant
// sign bits (signed) with a binary search of left shifts by 16, 8, 4, 2, 1,
// one step per cycle; the shift amount is built up one bit per step.
module normalizer (
   input logic          iClk,
   input logic          iRst,
   normalizer_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [31:0] val_q, val_d;
   logic [4:0]  shamt_q, shamt_d;
   logic        zero_q, zero_d;
   logic        sgn_q, sgn_d;

   logic [5:0]  step_n;
   logic        step_pass;
   logic        zero_in;

   // Operand with no normalizing bit: all zeros, or all ones in signed mode.
   assign zero_in = (bus.iD == 32'h0) || (bus.iSigned && (bus.iD == 32'hFFFF_FFFF));

   // Test for the current step: top n bits zero, or top n+1 bits equal to bit 31.
   always_comb begin
      step_n = 6'd1 << step_q;
      if (sgn_q) begin
         step_pass = ((val_q ^ {32{val_q[31]}}) >> (6'd31 - step_n)) == 32'h0;
      end else begin
         step_pass = (val_q >> (6'd32 - step_n)) == 32'h0;
      end
   end

   // Next-state: accept a start from IDLE/DONE, then walk steps 4 down to 0.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      val_d   = val_q;
      shamt_d = shamt_q;
      zero_d  = zero_q;
      sgn_d   = sgn_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (bus.iStart) begin
               state_d = StRun;
               step_d  = 3'd4;
               val_d   = bus.iD;
               sgn_d   = bus.iSigned;
               zero_d  = zero_in;
               shamt_d = 5'd0;
            end
         end
         StRun: begin
            // A zero-condition operand passes every test but must stay unshifted.
            if (!zero_q && step_pass) begin
               val_d           = val_q << step_n;
               shamt_d[step_q] = 1'b1;
            end
            if (step_q == 3'd0) begin
               state_d = StDone;
            end else begin
               step_d = step_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= StIdle;
         step_q  <= 3'd0;
         val_q   <= 32'h0;
         shamt_q <= 5'd0;
         zero_q  <= 1'b0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         val_q   <= val_d;
         shamt_q <= shamt_d;
         zero_q  <= zero_d;
         sgn_q   <= sgn_d;
      end
   end

   // Outputs come straight from flops.
   assign bus.oD     = val_q;
   assign bus.oShamt = shamt_q;
   assign bus.oZero  = zero_q;
   assign bus.oBusy  = (state_q == StRun);
   assign bus.oDone  = (state_q == StDone);

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for the normalizer: hand-computed vectors, cycle-exact
// busy/done timing, ignored mid-run starts, back-to-back starts and reset abort.
module tb_normalizer;

   logic iClk;
   logic iRst;
   int   n_checks;
   int   n_pass;

   normalizer_if bus ();

   normalizer u_dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus.slave)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present a start for sampling at the next posedge (cycle 0).
   task automatic launch(input logic [31:0] d, input logic sgn);
      bus.iStart  = 1'b1;
      bus.iD      = d;
      bus.iSigned = sgn;
   endtask

   // Walks cycles 1..6 after a launch, checking busy/done each cycle and the
   // result in cycle 6. Optionally pulses a foreign start in cycle 2.
   // Returns at the cycle-6 negedge so the caller may chain a start in DONE.
   task automatic expect_run(input string tag, input logic [31:0] exp_d,
                             input logic [4:0] exp_sh, input logic exp_z,
                             input logic pulse);
      for (int c = 1; c <= 6; c++) begin
         @(negedge iClk);
         if (c == 1) bus.iStart = 1'b0;
         if (pulse && c == 2) begin
            bus.iStart  = 1'b1;
            bus.iD      = 32'h0001_2345;
            bus.iSigned = 1'b0;
         end
         if (pulse && c == 3) bus.iStart = 1'b0;
         check_eq({tag, " busy"}, {31'h0, bus.oBusy}, {31'h0, (c <= 5)});
         check_eq({tag, " done"}, {31'h0, bus.oDone}, {31'h0, (c == 6)});
      end
      check_eq({tag, " oD"}, bus.oD, exp_d);
      check_eq({tag, " oShamt"}, {27'h0, bus.oShamt}, {27'h0, exp_sh});
      check_eq({tag, " oZero"}, {31'h0, bus.oZero}, {31'h0, exp_z});
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      iRst        = 1'b1;
      bus.iStart  = 1'b0;
      bus.iD      = 32'h0;
      bus.iSigned = 1'b0;
      repeat (2) @(negedge iClk);
      check_eq("rst oD", bus.oD, 32'h0);
      check_eq("rst oShamt", {27'h0, bus.oShamt}, 32'h0);
      check_eq("rst flags", {29'h0, bus.oZero, bus.oBusy, bus.oDone}, 32'h0);
      iRst = 1'b0;

      launch(32'h0000_0001, 1'b0); expect_run("u1", 32'h8000_0000, 5'd31, 1'b0, 1'b0);
      @(negedge iClk);
      check_eq("idle done", {31'h0, bus.oDone}, 32'h0);
      check_eq("idle hold oD", bus.oD, 32'h8000_0000);
      check_eq("idle hold oShamt", {27'h0, bus.oShamt}, 32'd31);

      launch(32'h0001_2345, 1'b0); expect_run("u12345", 32'h91A2_8000, 5'd15, 1'b0, 1'b0);
      @(negedge iClk);
      launch(32'h8000_0000, 1'b0); expect_run("u8000", 32'h8000_0000, 5'd0, 1'b0, 1'b0);
      @(negedge iClk);
      launch(32'hFFFF_FF80, 1'b1); expect_run("sFF80", 32'h8000_0000, 5'd24, 1'b0, 1'b0);
      @(negedge iClk);
      launch(32'h0000_0001, 1'b1); expect_run("s1", 32'h4000_0000, 5'd30, 1'b0, 1'b0);
      @(negedge iClk);
      launch(32'h8000_0000, 1'b1); expect_run("s8000", 32'h8000_0000, 5'd0, 1'b0, 1'b0);
      @(negedge iClk);
      launch(32'h0000_0000, 1'b0); expect_run("u0", 32'h0000_0000, 5'd0, 1'b1, 1'b0);
      @(negedge iClk);
      launch(32'hFFFF_FFFF, 1'b1); expect_run("sFFFF", 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
      @(negedge iClk);

      // Mid-run start ignored, then a start held in DONE chains back-to-back.
      launch(32'h0000_0001, 1'b0); expect_run("ign", 32'h8000_0000, 5'd31, 1'b0, 1'b1);
      launch(32'hFFFF_FF80, 1'b1); expect_run("b2b", 32'h8000_0000, 5'd24, 1'b0, 1'b0);
      @(negedge iClk);

      // Reset in cycle 3 aborts the run; restart the very next cycle.
      launch(32'h0000_0001, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge iClk);
         if (c == 1) bus.iStart = 1'b0;
         check_eq("abort busy", {31'h0, bus.oBusy}, 32'h1);
      end
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      check_eq("abort oD", bus.oD, 32'h0);
      check_eq("abort oShamt", {27'h0, bus.oShamt}, 32'h0);
      check_eq("abort flags", {29'h0, bus.oZero, bus.oBusy, bus.oDone}, 32'h0);
      launch(32'h0000_0001, 1'b1); expect_run("post rst", 32'h4000_0000, 5'd30, 1'b0, 1'b0);
      @(negedge iClk);
      check_eq("final done", {31'h0, bus.oDone}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
